// File: rtl/led_ctl_multi.sv
// Purpose: UART-fed LED controller with a byte parser, four display modes and a tick prescaler.
// Latency: a byte accepted at edge k updates the display reg at k and reaches led_o at k+2.
// Backpressure: none; one byte is taken per rising edge of rx_data_rdy and nothing stalls the UART.
//
// Ports:
//   clk_rx        receive-domain clock
//   rst_clk_rx_n  asynchronous active-low reset
//   btn_clk_rx    debounced button, synchronous to clk_rx
//   rx_data       received byte, valid while rx_data_rdy is high
//   rx_data_rdy   byte-ready strobe; only its rising edge is acted on
//   led_o         registered LED drive, LED_W bits
//   mode_o        registered current mode (0 direct, 1 blink, 2 rotate, 3 hold)
//
// Build option: define LED_CTL_ACTIVE_LOW_EN for active-low LED drive
// (led_o is the inverse of the pipeline register and resets to all ones).
module led_ctl_multi #(
    parameter int LED_W    = 8,
    parameter int TICK_DIV = 25000000
) (
    input  logic             clk_rx,
    input  logic             rst_clk_rx_n,
    input  logic             btn_clk_rx,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_rdy,
    output logic [LED_W-1:0] led_o,
    output logic [1:0]       mode_o
);

    localparam int                CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TICK_DIV - 1);
    localparam logic [7:0]        CMD_MODE = 8'h4D;  // 'M': next byte is a mode argument

`ifdef LED_CTL_ACTIVE_LOW_EN
    localparam logic [LED_W-1:0] LED_RST = '1;
`else
    localparam logic [LED_W-1:0] LED_RST = '0;
`endif

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_ARG  = 1'b1
    } ps_t;

    ps_t              ps_q, ps_d;
    logic             old_rdy;
    logic             byte_acc;
    logic             disp_ld;
    logic             mode_ld;
    logic [LED_W-1:0] disp_q;
    logic [LED_W-1:0] disp_shift;
    logic [LED_W-1:0] rot_q;
    logic [LED_W-1:0] pipe_q;
    logic [LED_W-1:0] pipe_d;
    logic [LED_W-1:0] led_drv;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tick;
    logic             phase_q;

    // A level held high on rx_data_rdy yields exactly one byte.
    assign byte_acc = rx_data_rdy & ~old_rdy;

    // New data enters at the LSB; the oldest byte drops off the MSB.
    generate
        if (LED_W == 8) begin : g_load
            assign disp_shift = rx_data;
        end else begin : g_shift
            assign disp_shift = {disp_q[LED_W-9:0], rx_data};
        end
    endgenerate

    // Parser: 'M' in IDLE arms the argument slot; in ARG every byte
    // (including 'M') is consumed as the mode argument.
    always_comb begin
        ps_d    = ps_q;
        disp_ld = 1'b0;
        mode_ld = 1'b0;
        if (byte_acc) begin
            case (ps_q)
                PS_IDLE: begin
                    if (rx_data == CMD_MODE) ps_d = PS_ARG;
                    else                     disp_ld = 1'b1;
                end
                PS_ARG: begin
                    mode_ld = 1'b1;
                    ps_d    = PS_IDLE;
                end
                default: ps_d = PS_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            ps_q    <= PS_IDLE;
            old_rdy <= 1'b0;
        end else begin
            ps_q    <= ps_d;
            old_rdy <= rx_data_rdy;
        end
    end

    // Free-running prescaler; mode changes never disturb it.
    assign tick = (cnt_q == CNT_MAX);

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= tick ? '0 : cnt_q + 1'b1;
            phase_q <= phase_q ^ tick;
        end
    end

    // Display, mode and rotate registers. A reload of the rotate register
    // (new data, or selecting rotate mode) takes priority over a tick.
    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            disp_q <= '0;
            mode_q <= 2'd0;
            rot_q  <= '0;
        end else begin
            if (disp_ld) disp_q <= disp_shift;
            if (mode_ld) mode_q <= rx_data[1:0];

            if (disp_ld)
                rot_q <= disp_shift;
            else if (mode_ld && rx_data[1:0] == 2'd2)
                rot_q <= disp_q;
            else if (mode_q == 2'd2 && tick && !btn_clk_rx)
                rot_q <= {rot_q[LED_W-2:0], rot_q[LED_W-1]};
        end
    end

    // Per-mode pipeline value; hold mode simply recirculates.
    always_comb begin
        pipe_d = pipe_q;
        case (mode_q)
            2'd0: pipe_d = btn_clk_rx
                         ? disp_q ^ {disp_q[LED_W/2-1:0], disp_q[LED_W-1:LED_W/2]}
                         : disp_q;
            2'd1: pipe_d = (btn_clk_rx || phase_q) ? disp_q : '0;
            2'd2: pipe_d = rot_q;
            default: pipe_d = pipe_q;
        endcase
    end

`ifdef LED_CTL_ACTIVE_LOW_EN
    assign led_drv = ~pipe_q;
`else
    assign led_drv = pipe_q;
`endif

    always_ff @(posedge clk_rx or negedge rst_clk_rx_n) begin
        if (!rst_clk_rx_n) begin
            pipe_q <= '0;
            led_o  <= LED_RST;
            mode_o <= 2'd0;
        end else begin
            pipe_q <= pipe_d;
            led_o  <= led_drv;
            mode_o <= mode_q;
        end
    end

endmodule

// File: tb/tb_led_ctl_multi.sv
// Bench for led_ctl_multi with LED_W=16, TICK_DIV=4: directed scenarios
// followed by randomized byte traffic, all compared every cycle against a
// behavioural model of the controller.
module tb_led_ctl_multi;

    localparam int LED_W    = 16;
    localparam int TICK_DIV = 4;

`ifdef LED_CTL_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    logic        clk_rx = 1'b0;
    logic        rst_clk_rx_n;
    logic        btn_clk_rx;
    logic [7:0]  rx_data;
    logic        rx_data_rdy;
    logic [15:0] led_o;
    logic [1:0]  mode_o;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state.
    logic [15:0] m_disp, m_rot, m_pipe, m_led;
    logic [1:0]  m_mode, m_mode_o;
    bit          m_arg, m_prev_rdy;
    int          m_cyc;  // clock edges since reset release

    led_ctl_multi #(.LED_W(LED_W), .TICK_DIV(TICK_DIV)) dut (
        .clk_rx      (clk_rx),
        .rst_clk_rx_n(rst_clk_rx_n),
        .btn_clk_rx  (btn_clk_rx),
        .rx_data     (rx_data),
        .rx_data_rdy (rx_data_rdy),
        .led_o       (led_o),
        .mode_o      (mode_o)
    );

    always #5 clk_rx = ~clk_rx;

    function automatic logic [15:0] rotl(input logic [15:0] x, input int n);
        return 16'((x << n) | (x >> (16 - n)));
    endfunction

    function automatic logic [15:0] drive(input logic [15:0] x);
        return ACT_LOW ? ~x : x;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_disp = '0; m_rot = '0; m_pipe = '0; m_led = drive(16'h0000);
        m_mode = '0; m_mode_o = '0; m_arg = 0; m_prev_rdy = 0; m_cyc = 0;
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic step();
        logic [15:0] nxt;
        bit acc, tk, ph;
        @(posedge clk_rx);
        if (!rst_clk_rx_n) begin
            model_reset();
        end else begin
            acc = rx_data_rdy && !m_prev_rdy;
            tk  = (m_cyc % TICK_DIV) == TICK_DIV - 1;
            ph  = ((m_cyc / TICK_DIV) % 2) == 1;  // ticks so far, odd/even
            case (m_mode)
                2'd0:    nxt = btn_clk_rx ? (m_disp ^ rotl(m_disp, 8)) : m_disp;
                2'd1:    nxt = (btn_clk_rx || ph) ? m_disp : 16'h0000;
                2'd2:    nxt = m_rot;
                default: nxt = m_pipe;
            endcase
            m_led    = drive(m_pipe);
            m_mode_o = m_mode;
            m_pipe   = nxt;
            if (acc && m_arg) begin
                m_mode = rx_data[1:0];
                m_arg  = 0;
                if (rx_data[1:0] == 2'd2) m_rot = m_disp;
                else if (m_mode_o == 2'd2 && tk && !btn_clk_rx) m_rot = rotl(m_rot, 1);
            end else if (acc && rx_data != 8'h4D) begin
                m_disp = {m_disp[7:0], rx_data};
                m_rot  = m_disp;
            end else begin
                if (acc) m_arg = 1;
                if (m_mode == 2'd2 && tk && !btn_clk_rx) m_rot = rotl(m_rot, 1);
            end
            m_prev_rdy = rx_data_rdy;
            m_cyc++;
        end
        @(negedge clk_rx);
        chk("model_led", led_o, m_led);
        chk("model_mode", {14'd0, mode_o}, {14'd0, m_mode_o});
    endtask

    task automatic apply_reset();
        rst_clk_rx_n = 1'b0;
        model_reset();
        #1;
        chk("reset_async_led", led_o, drive(16'h0000));
        step();
        step();
        rst_clk_rx_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_data_rdy = 1'b1;
        step();
        rx_data_rdy = 1'b0;
        step();
    endtask

    initial begin
        int          last;
        int          k;
        bit          seen;
        logic [15:0] prv;

        rst_clk_rx_n = 1'b0;
        btn_clk_rx   = 1'b0;
        rx_data      = 8'h00;
        rx_data_rdy  = 1'b0;

        // 1: reset state, two data bytes in direct mode.
        apply_reset();
        chk("reset_led", led_o, drive(16'h0000));
        chk("reset_mode", {14'd0, mode_o}, 16'd0);
        send_byte(8'h12);
        send_byte(8'h34);
        chk("latency_partial", led_o, drive(16'h0012));
        step();
        chk("direct_1234", led_o, drive(16'h1234));
        chk("direct_mode", {14'd0, mode_o}, 16'd0);

        // 2: held strobe gives one byte; button XORs with the half-rotated value.
        rx_data = 8'h55;
        rx_data_rdy = 1'b1;
        repeat (10) step();
        rx_data_rdy = 1'b0;
        step();
        send_byte(8'h56);
        step();
        chk("held_rdy_5556", led_o, drive(16'h5556));
        btn_clk_rx = 1'b1;
        step();
        step();
        chk("direct_xor", led_o, drive(16'h0303));
        btn_clk_rx = 1'b0;

        // 3: blink with a 4-cycle half period; button forces steady display.
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h4D);
        send_byte(8'h01);
        repeat (4) step();
        chk("blink_mode", {14'd0, mode_o}, 16'd1);
        prv  = led_o;
        last = -1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (led_o !== prv) begin
                if (last >= 0) chk("blink_period", 16'(i - last), 16'd4);
                last = i;
                prv  = led_o;
            end
            chk("blink_value", 16'(led_o == drive(16'h00FF) || led_o == drive(16'h0000)), 16'd1);
        end
        chk("blink_toggled", 16'(last >= 0), 16'd1);
        btn_clk_rx = 1'b1;
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("blink_btn_steady", led_o, drive(16'h00FF));
        end
        btn_clk_rx = 1'b0;

        // 4: rotate mode, pause, reload mid-rotation.
        send_byte(8'h80);
        send_byte(8'h01);
        send_byte(8'h4D);
        send_byte(8'h02);
        seen = (led_o == drive(16'h8001));
        k = 0;
        while (led_o !== drive(16'h0003) && k < 40) begin
            step();
            if (led_o == drive(16'h8001)) seen = 1;
            k++;
        end
        chk("rot_reach_0003", 16'(k < 40), 16'd1);
        chk("rot_saw_8001", 16'(seen), 16'd1);
        k = 0;
        while (led_o === drive(16'h0003) && k < 20) begin
            step();
            k++;
        end
        chk("rot_spacing", 16'(k), 16'd4);
        chk("rot_third", led_o, drive(16'h0006));
        btn_clk_rx = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rot_pause", led_o, drive(16'h0006));
        end
        btn_clk_rx = 1'b0;
        send_byte(8'hAA);
        step();
        chk("rot_reload", led_o, drive(16'h01AA));

        // 5: reset while an argument is pending discards it.
        send_byte(8'h4D);
        apply_reset();
        send_byte(8'h4D);
        send_byte(8'h4D);
        step();
        chk("arg_after_reset_mode", {14'd0, mode_o}, 16'd1);
        btn_clk_rx = 1'b1;
        repeat (3) step();
        chk("arg_after_reset_disp", led_o, drive(16'h0000));
        btn_clk_rx = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            btn_clk_rx  = ($urandom_range(0, 3) == 0);
            rx_data     = ($urandom_range(0, 3) == 0) ? 8'h4D : 8'($urandom);
            rx_data_rdy = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            rx_data_rdy = 1'b0;
            repeat ($urandom_range(0, 6)) step();
            if ($urandom_range(0, 99) == 0) apply_reset();
        end
        btn_clk_rx = 1'b0;

        // 6: reset value and polarity of the LED drive.
        apply_reset();
        chk("polarity_reset", led_o, ACT_LOW ? 16'hFFFF : 16'h0000);
        send_byte(8'h0F);
        send_byte(8'h00);
        step();
        chk("polarity_data", led_o, ACT_LOW ? 16'hF0FF : 16'h0F00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/led_ctl_multi.md
Name: led_ctl_multi

Overview:
- Parametrised successor to the UART-driven LED controller. Sits behind the UART receiver in the clk_rx domain.
- Captures received bytes on each rising edge of rx_data_rdy. A small command parser routes each byte either into an LED_W-bit display register or into a mode register.
- Drives led_o in one of four modes: direct/XOR, blink, rotate, or hold. Blink and rotate are paced by an internal tick prescaler.

Parameters:
- LED_W, 8, LED output width; multiple of 8, minimum 8.
- TICK_DIV, 25000000, clk_rx cycles per tick; minimum 2. The prescaler counter is $clog2(TICK_DIV) bits wide.

Ports:
- clk_rx  input  1  clock.
- rst_clk_rx_n  input  1  reset, asynchronous, active-low.
- btn_clk_rx  input  1  debounced button, already synchronous to clk_rx.
- rx_data  input  8  received byte; valid while rx_data_rdy is high.
- rx_data_rdy  input  1  byte-ready strobe from the UART receiver.
- led_o  output  LED_W  registered LED drive.
- mode_o  output  2  registered current mode.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled upstream) clears all state:
  - led_o, mode_o, display reg, rotate reg, pipeline reg, prescaler and blink phase all 0.
  - Parser returns to IDLE.
  - old_rdy resets to 0.
- Edge detect: old_rdy <= rx_data_rdy every cycle. A byte is accepted on an edge where rx_data_rdy=1 and old_rdy=0. A level held high accepts exactly one byte.
- Parser FSM, two states:
  - IDLE, byte==0x4D ('M'): go to ARG; display reg unchanged.
  - IDLE, any other byte: data byte. Display reg <= {disp[LED_W-9:0], byte}, i.e. shift in at the LSB with the oldest byte falling off the MSB. For LED_W=8 this is a plain load. Rotate reg reloads from the new display value.
  - ARG, any byte (including 0x4D): mode <= byte[1:0]; go to IDLE. byte[7:2] is ignored.
  - Entering mode 2 reloads the rotate reg from the display reg.
  - Byte value 0x4D cannot be written as data; this is accepted.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is a one-cycle pulse on the wrap cycle.
  - Blink phase toggles on each tick.
  - Prescaler free-runs in all modes and is never reset by a mode change.
- Pipeline value per mode (nxt):
  - Mode 0 DIRECT: btn=0 → disp; btn=1 → disp XOR (disp rotated by LED_W/2).
  - Mode 1 BLINK: phase=1 → disp; phase=0 → all zeros. btn=1 forces disp, with no blanking.
  - Mode 2 ROTATE: on tick with btn=0, rotate reg rotates left by 1; btn=1 pauses. nxt = rotate reg.
  - Mode 3 HOLD: nxt = current pipeline value (frozen); new data still updates disp.
- Latency: accept at edge k → disp updated at k → pipeline reg at k+1 → led_o at k+2.
- mode_o follows the mode register with one cycle of delay.
- Simultaneous events:
  - A tick coinciding with a data byte in mode 2: the reload wins and no rotate occurs that cycle.
  - A mode change and a tick in the same cycle: the new mode applies from the next cycle.
- Reset mid-ARG: the parser returns to IDLE and the pending argument is lost.

Optional Feature:
- LED_CTL_ACTIVE_LOW_EN defined:
  - led_o is the bitwise inverse of the pipeline reg.
  - Reset value of led_o is all ones.
  - Blink-off drives all ones.
- Undefined: active-high behaviour as above; reset value is all zeros.

Test Plan:
All scenarios use LED_W=16 and TICK_DIV=4 unless stated.
1. Reset, then send 0x12 and 0x34 in mode 0 with btn=0 → led_o=0x1234, appearing 2 cycles after the second accept; mode_o=0.
2. rx_data_rdy held high for 10 cycles with 0x55, then 0x56 on a fresh edge → disp=0x5556 (exactly one byte per edge). btn=1 → led_o=0x5556^0x5655=0x0303.
3. Send 'M',0x01 with disp=0x00FF, btn=0 → led_o alternates 0x00FF/0x0000 every 4 cycles. btn=1 → steady 0x00FF.
4. Send 'M',0x02 with disp=0x8001 → led_o sequence 0x8001, 0x0003, 0x0006 at 4-cycle spacing. btn=1 freezes the pattern. Sending data 0xAA mid-rotation reloads to 0x01AA.
5. Send 'M', then reset mid-ARG, then 0x4D,0x4D → parser consumes the second 0x4D as argument, mode=1; disp stays 0.
6. With LED_CTL_ACTIVE_LOW_EN defined: reset → led_o=0xFFFF; send 0x0F,0x00 → led_o=0xF0FF.
